fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the write port of one FIFO between `NUM_REQ` requesters in the FIFO's write clock domain. It takes a level `req` plus data from each requester and issues at most one registered `wr_en`/`wdata` beat per cycle to the FIFO. It returns a one-cycle `gnt` acknowledge to the winner and never writes into a full FIFO. It sits directly in front of the FIFO write side (`wr_en`, `wdata`, `full`) and keeps a saturating count of back-pressure stall cycles.

---
 rtl/fifo_wr_arbiter.sv | 83 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the write port of a single FIFO.
// Issues at most one registered write per cycle. It stops issuing writes
// under FIFO back-pressure and keeps a saturating count of blocked cycles.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic                     full,
    input  logic                     afull,
    input  logic                     stall_clr,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     wr_en,
    output logic [WIDTH-1:0]         wdata,
    output logic [CNT_WIDTH-1:0]     stall_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] elig;
    logic               blocked;
    logic               win_found;
    int                 win_idx;

    // A requester granted last cycle is masked so its held req is not taken twice.
    // A write on the port that will fill the FIFO blocks any new write.
    always_comb begin
        elig    = req & ~gnt;
        blocked = full | (wr_en & afull);
    end

    // Pick the first eligible index at or above rr_ptr, wrapping around.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = 0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Register the grant, the write beat and the rotating priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt    <= '0;
            wr_en  <= 1'b0;
            wdata  <= '0;
            rr_ptr <= '0;
        end else if (win_found && !blocked) begin
            gnt    <= NUM_REQ'(1) << win_idx;
            wr_en  <= 1'b1;
            wdata  <= req_data[win_idx*WIDTH +: WIDTH];
            rr_ptr <= PTR_W'((win_idx + 1) % NUM_REQ);
        end else begin
            gnt    <= '0;
            wr_en  <= 1'b0;
            wdata  <= '0;
        end
    end

    // Count cycles where someone wants the port but back-pressure holds it off.
    // A clear takes precedence over an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (win_found && blocked && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a vector table followed by multi-cycle sequences.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        full;
    logic        afull;
    logic        stall_clr;
    logic [3:0]  gnt;
    logic        wr_en;
    logic [7:0]  wdata;
    logic [7:0]  stall_cnt;
    logic [3:0]  gnt4;
    logic        wr_en4;
    logic [7:0]  wdata4;
    logic [3:0]  stall_cnt4;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(.WIDTH(8), .NUM_REQ(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .full(full),
        .afull(afull), .stall_clr(stall_clr), .gnt(gnt), .wr_en(wr_en),
        .wdata(wdata), .stall_cnt(stall_cnt)
    );

    fifo_wr_arbiter #(.WIDTH(8), .NUM_REQ(4), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .full(full),
        .afull(afull), .stall_clr(stall_clr), .gnt(gnt4), .wr_en(wr_en4),
        .wdata(wdata4), .stall_cnt(stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic       afull;
        logic       clr;
        logic [3:0] gnt;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] stall;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("onehot_gnt", {31'd0, $onehot0(gnt)}, 32'd1);
        chk("wr_en_eq_or_gnt", {31'd0, wr_en}, {31'd0, |gnt});
    endtask

    initial begin
        // fair rotation
        vecs[0]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h11, 8'd0};
        vecs[1]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 8'h22, 8'd0};
        vecs[2]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 8'h33, 8'd0};
        vecs[3]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 8'h44, 8'd0};
        vecs[4]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h11, 8'd0};
        vecs[5]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 8'h22, 8'd0};
        // full back-pressure for 5 cycles, last grant was requester 1
        vecs[6]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 8'd1};
        vecs[7]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 8'd2};
        vecs[8]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 8'd3};
        vecs[9]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 8'd4};
        vecs[10] = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 8'd5};
        vecs[11] = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 8'h33, 8'd5};
        vecs[12] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 8'd5};
        vecs[13] = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 8'd0};
        // lone requester 2: grant every other cycle
        vecs[14] = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 8'h33, 8'd0};
        vecs[15] = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 8'd0};
        vecs[16] = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 8'h33, 8'd0};
        vecs[17] = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 8'd0};
        // almost-full guard, rr_ptr=3 on entry
        vecs[18] = '{4'b0011, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, 8'h11, 8'd0};
        vecs[19] = '{4'b0011, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h00, 8'd1};
        vecs[20] = '{4'b0011, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, 8'h22, 8'd1};
        vecs[21] = '{4'b0011, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h00, 8'd2};
        vecs[22] = '{4'b0011, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, 8'h11, 8'd2};

        rst       = 1'b1;
        req       = '0;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        full      = 1'b0;
        afull     = 1'b0;
        stall_clr = 1'b0;
        #1;
        chk("reset_gnt", {28'd0, gnt}, 32'd0);
        chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
        chk("reset_wdata", {24'd0, wdata}, 32'd0);
        chk("reset_stall", {24'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) begin
            req       = vecs[i].req;
            full      = vecs[i].full;
            afull     = vecs[i].afull;
            stall_clr = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_gnt", i), {28'd0, gnt}, {28'd0, vecs[i].gnt});
            chk($sformatf("vec%0d_wr_en", i), {31'd0, wr_en}, {31'd0, vecs[i].wr});
            chk($sformatf("vec%0d_wdata", i), {24'd0, wdata}, {24'd0, vecs[i].wdata});
            chk($sformatf("vec%0d_stall", i), {24'd0, stall_cnt}, {24'd0, vecs[i].stall});
        end

        // stall counter saturation on the 4-bit instance, then clear
        req = '0; full = 1'b0; afull = 1'b0; stall_clr = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req  = 4'b1111;
        full = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("sat_gnt_while_full", {28'd0, gnt4}, 32'd0);
            if (i == 15 || i == 20) begin
                chk($sformatf("sat_cnt4_at_%0d", i), {28'd0, stall_cnt4}, 32'd15);
                chk($sformatf("cnt8_at_%0d", i), {24'd0, stall_cnt}, i);
            end
        end
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        chk("clr_cnt4", {28'd0, stall_cnt4}, 32'd0);
        chk("clr_cnt8", {24'd0, stall_cnt}, 32'd0);

        // reset mid-run
        step();
        step();
        chk("pre_rst_stall", {24'd0, stall_cnt}, 32'd2);
        full = 1'b0;
        step();
        chk("pre_rst_gnt0", {28'd0, gnt}, 32'b0001);
        step();
        chk("pre_rst_gnt1", {28'd0, gnt}, 32'b0010);
        chk("pre_rst_wdata", {24'd0, wdata}, 32'h22);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_gnt", {28'd0, gnt}, 32'd0);
        chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("midrst_wdata", {24'd0, wdata}, 32'd0);
        chk("midrst_stall", {24'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_gnt", {28'd0, gnt}, 32'b0001);
        chk("post_rst_wdata", {24'd0, wdata}, 32'h11);
        step();
        chk("post_rst_gnt2", {28'd0, gnt}, 32'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
